// File: rtl/rprelu_param_ctrl.sv
// rprelu parameter loader: fills a shadow bank from a stream, then commits
// it to the active bank once in-flight rprelu samples have drained.
module rprelu_param_ctrl #(
  parameter int PARA_WIDTH   = 16,
  parameter int CHANNEL_NUM  = 128,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_start,
  input  logic para_in_valid,
  output logic para_in_ready,
  input  logic [PARA_WIDTH-1:0] para_in,
  output logic load_done,
  input  logic swap_req,
  input  logic data_in_valid,
  output logic data_in_stall,
  output logic rprelu_valid,
  input  logic rprelu_out_valid,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] beta,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] gamma,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] zeta,
  output logic params_ready,
  output logic drop_err
);

  localparam int IW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] LAST = IW'(CHANNEL_NUM - 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  typedef logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bank_t;
  typedef enum logic [2:0] {
    IDLE, LOAD_B, LOAD_G, LOAD_Z, FULL
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] infl_q, infl_d;
  bank_t         shb_q, shb_d, shg_q, shg_d, shz_q, shz_d;
  bank_t         acb_q, acb_d, acg_q, acg_d, acz_q, acz_d;
  logic          pend_q, pend_d;
  logic          prdy_q, prdy_d;
  logic          done_q, done_d;
  logic          derr_q, derr_d;
  logic          accept, last, commit;

  assign para_in_ready = (state_q == LOAD_B) |
                         (state_q == LOAD_G) |
                         (state_q == LOAD_Z);
  assign data_in_stall = ~prdy_q | pend_q;
  assign rprelu_valid  = data_in_valid & ~data_in_stall;
  assign accept = para_in_valid & para_in_ready;
  assign last   = (idx_q == LAST);
  assign commit = pend_q & (infl_q == '0);

  assign beta         = acb_q;
  assign gamma        = acg_q;
  assign zeta         = acz_q;
  assign params_ready = prdy_q;
  assign load_done    = done_q;
  assign drop_err     = derr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shb_d   = shb_q;
    shg_d   = shg_q;
    shz_d   = shz_q;
    acb_d   = acb_q;
    acg_d   = acg_q;
    acz_d   = acz_q;
    pend_d  = pend_q;
    prdy_d  = prdy_q;
    done_d  = 1'b0;
    derr_d  = derr_q;
    infl_d  = infl_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD_B;
          idx_d   = '0;
        end
      end
      LOAD_B: begin
        if (accept) begin
          shb_d[idx_q] = para_in;
          idx_d = last ? '0 : idx_q + 1'b1;
          if (last) state_d = LOAD_G;
        end
      end
      LOAD_G: begin
        if (accept) begin
          shg_d[idx_q] = para_in;
          idx_d = last ? '0 : idx_q + 1'b1;
          if (last) state_d = LOAD_Z;
        end
      end
      LOAD_Z: begin
        if (accept) begin
          shz_d[idx_q] = para_in;
          idx_d = last ? '0 : idx_q + 1'b1;
          if (last) begin
            state_d = FULL;
            done_d  = 1'b1;
          end
        end
      end
      FULL: begin
        // a restart discards the shadow set unless a commit is queued
        if (load_start && !pend_q) begin
          state_d = LOAD_B;
          idx_d   = '0;
        end else if (swap_req) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      acb_d   = shb_q;
      acg_d   = shg_q;
      acz_d   = shz_q;
      prdy_d  = 1'b1;
      pend_d  = 1'b0;
      state_d = IDLE;
    end
    if (rprelu_valid && !rprelu_out_valid) begin
      if (infl_q == CMAX) derr_d = 1'b1;
      else                infl_d = infl_q + 1'b1;
    end else if (!rprelu_valid && rprelu_out_valid) begin
      if (infl_q != '0) infl_d = infl_q - 1'b1;
    end
    if (data_in_valid && data_in_stall) derr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shb_q   <= '0;
      shg_q   <= '0;
      shz_q   <= '0;
      acb_q   <= '0;
      acg_q   <= '0;
      acz_q   <= '0;
      pend_q  <= 1'b0;
      prdy_q  <= 1'b0;
      done_q  <= 1'b0;
      derr_q  <= 1'b0;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shb_q   <= shb_d;
      shg_q   <= shg_d;
      shz_q   <= shz_d;
      acb_q   <= acb_d;
      acg_q   <= acg_d;
      acz_q   <= acz_d;
      pend_q  <= pend_d;
      prdy_q  <= prdy_d;
      done_q  <= done_d;
      derr_q  <= derr_d;
      infl_q  <= infl_d;
    end
  end

endmodule
